ocp_bus_decoder: RTL

OCP_BUS_DECODER -- requirements
Module: ocp_bus_decoder

---
 rtl/ocp_bus_decoder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ocp_bus_decoder.sv
// ocp_bus_decoder: single-master, two-slave OCP address decoder.
// The master command is accepted in IDLE, latched, and replayed from registers
// on the selected slave port. Writes are posted. Reads return the slave
// response for one cycle. Unmapped reads and watchdog expiry return ERR.
module ocp_bus_decoder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BEN_WIDTH  = DATA_WIDTH / 8,
    parameter logic [31:0] S0_BASE    = 32'h0000_0000,
    parameter logic [31:0] S0_MASK    = 32'h8000_0000,
    parameter logic [31:0] S1_BASE    = 32'hF000_0000,
    parameter logic [31:0] S1_MASK    = 32'hF000_0000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  nrst,
    // master side
    input  logic [ADDR_WIDTH-1:0] i_MAddr,
    input  logic [2:0]            i_MCmd,
    input  logic [DATA_WIDTH-1:0] i_MData,
    input  logic [BEN_WIDTH-1:0]  i_MByteEn,
    output logic                  o_SCmdAccept,
    output logic [DATA_WIDTH-1:0] o_SData,
    output logic [1:0]            o_SResp,
    // slave 0
    output logic [ADDR_WIDTH-1:0] o_s0_MAddr,
    output logic [2:0]            o_s0_MCmd,
    output logic [DATA_WIDTH-1:0] o_s0_MData,
    output logic [BEN_WIDTH-1:0]  o_s0_MByteEn,
    input  logic                  i_s0_SCmdAccept,
    input  logic [DATA_WIDTH-1:0] i_s0_SData,
    input  logic [1:0]            i_s0_SResp,
    // slave 1
    output logic [ADDR_WIDTH-1:0] o_s1_MAddr,
    output logic [2:0]            o_s1_MCmd,
    output logic [DATA_WIDTH-1:0] o_s1_MData,
    output logic [BEN_WIDTH-1:0]  o_s1_MByteEn,
    input  logic                  i_s1_SCmdAccept,
    input  logic [DATA_WIDTH-1:0] i_s1_SData,
    input  logic [1:0]            i_s1_SResp
);

    localparam logic [2:0]  CMD_IDLE  = 3'd0;
    localparam logic [2:0]  CMD_WRITE = 3'd1;
    localparam logic [2:0]  CMD_READ  = 3'd2;
    localparam logic [1:0]  RESP_NULL = 2'd0;
    localparam logic [1:0]  RESP_ERR  = 2'd3;
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_RESP,
        ST_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            cmd_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [BEN_WIDTH-1:0]  ben_q;
    logic                  port_q;   // 0 = slave 0, 1 = slave 1
    logic [15:0]           wdog;

    logic                  cmd_valid;
    logic                  hit0;
    logic                  hit1;
    logic                  sel_accept;
    logic [1:0]            sel_resp;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [15:0]           wdog_next;
    logic                  wdog_expired;

    // Address decode of the live master address; slave 0 wins on overlap.
    always_comb begin
        hit0 = (i_MAddr & ADDR_WIDTH'(S0_MASK)) == ADDR_WIDTH'(S0_BASE);
        hit1 = (i_MAddr & ADDR_WIDTH'(S1_MASK)) == ADDR_WIDTH'(S1_BASE);
    end

    // Handshake signals of the latched port only; the other port is ignored.
    always_comb begin
        sel_accept   = port_q ? i_s1_SCmdAccept : i_s0_SCmdAccept;
        sel_resp     = port_q ? i_s1_SResp      : i_s0_SResp;
        sel_data     = port_q ? i_s1_SData      : i_s0_SData;
        wdog_next    = wdog + 16'd1;
        wdog_expired = (wdog_next == TIMEOUT_C);
    end

    // NOTE: o_SCmdAccept is combinational, so it is gated by nrst to keep every
    // output at 0 while reset is held even though the FSM already sits in IDLE.
    assign cmd_valid    = (i_MCmd == CMD_WRITE) || (i_MCmd == CMD_READ);
    assign o_SCmdAccept = nrst && (state == ST_IDLE) && cmd_valid;

    // Replay the latched command on the selected port while in CMD; idle otherwise.
    always_comb begin
        o_s0_MAddr   = '0;
        o_s0_MCmd    = CMD_IDLE;
        o_s0_MData   = '0;
        o_s0_MByteEn = '0;
        o_s1_MAddr   = '0;
        o_s1_MCmd    = CMD_IDLE;
        o_s1_MData   = '0;
        o_s1_MByteEn = '0;
        if (state == ST_CMD) begin
            if (port_q) begin
                o_s1_MAddr   = addr_q;
                o_s1_MCmd    = cmd_q;
                o_s1_MData   = data_q;
                o_s1_MByteEn = ben_q;
            end else begin
                o_s0_MAddr   = addr_q;
                o_s0_MCmd    = cmd_q;
                o_s0_MData   = data_q;
                o_s0_MByteEn = ben_q;
            end
        end
    end

    // Transaction FSM with latched command fields, watchdog and registered response.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            cmd_q   <= CMD_IDLE;
            data_q  <= '0;
            ben_q   <= '0;
            port_q  <= 1'b0;
            wdog    <= '0;
            o_SResp <= RESP_NULL;
            o_SData <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= i_MAddr;
                        cmd_q  <= i_MCmd;
                        data_q <= i_MData;
                        ben_q  <= i_MByteEn;
                        port_q <= !hit0;
                        wdog   <= '0;
                        if (hit0 || hit1) begin
                            state <= ST_CMD;
                        end else if (i_MCmd == CMD_READ) begin
                            state   <= ST_DONE;
                            o_SResp <= RESP_ERR;
                            o_SData <= '0;
                        end
                        // Unmapped write: dropped, stay in IDLE.
                    end
                end

                ST_CMD: begin
                    wdog <= wdog_next;
                    if (sel_accept) begin
                        state <= (cmd_q == CMD_READ) ? ST_RESP : ST_IDLE;
                    end else if (wdog_expired) begin
                        if (cmd_q == CMD_READ) begin
                            state   <= ST_DONE;
                            o_SResp <= RESP_ERR;
                            o_SData <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_RESP: begin
                    wdog <= wdog_next;
                    // A response in the expiry cycle takes precedence over ERR.
                    if (sel_resp != RESP_NULL) begin
                        state   <= ST_DONE;
                        o_SResp <= sel_resp;
                        o_SData <= sel_data;
                    end else if (wdog_expired) begin
                        state   <= ST_DONE;
                        o_SResp <= RESP_ERR;
                        o_SData <= '0;
                    end
                end

                ST_DONE: begin
                    state   <= ST_IDLE;
                    o_SResp <= RESP_NULL;
                    o_SData <= '0;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
